// File: rtl/fighter_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_controller
//  Description : Per-player character engine. Walk / jump physics, attack
//                timing and hit-stun, all advanced on the frame tick.
//                Outputs are registered and feed the sprite renderer and the
//                collision / health logic directly.
//  Revision    : 1.0  initial release
// ============================================================================
module fighter_controller #(
   parameter int X_INIT        = 24,
   parameter int Y_GROUND      = 32,
   parameter int X_MIN         = 8,
   parameter int X_MAX         = 88,
   parameter int STEP          = 1,
   parameter int JUMP_V        = 6,
   parameter int GRAVITY       = 1,
   parameter int ATTACK_TICKS  = 12,
   parameter int HITSTUN_TICKS = 12,
   parameter int KNOCKBACK     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_attack,
   input  logic [6:0] opp_x,
   input  logic       hit_in,
   output logic [6:0] x,
   output logic [6:0] y,
   output logic       in_air,
   output logic [1:0] move_state,
   output logic [2:0] character_state,
   output logic       mirror,
   output logic       hit_strobe
);

   localparam logic [7:0]        c_ATK_LOAD  = 8'(ATTACK_TICKS - 1);
   localparam logic [7:0]        c_ATK_HALF  = 8'(ATTACK_TICKS / 2);
   localparam logic [7:0]        c_STUN_LOAD = 8'(HITSTUN_TICKS - 1);
   localparam logic signed [7:0] c_Y_GND_S   = 8'(Y_GROUND);
   localparam logic signed [4:0] c_GRAV_S    = 5'(GRAVITY);
   localparam logic [1:0]        c_MV_STILL  = 2'b00;
   localparam logic [1:0]        c_MV_FWD    = 2'b01;
   localparam logic [1:0]        c_MV_BACK   = 2'b10;

   typedef enum logic [2:0] {
      ST_NORMAL = 3'b000,
      ST_ATTACK = 3'b001,
      ST_HURT   = 3'b010
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [6:0]         r_x, w_x_nxt;
   logic [6:0]         r_y, w_y_nxt;
   logic signed [4:0]  r_vy, w_vy_nxt;
   logic               r_in_air, w_in_air_nxt;
   logic [1:0]         r_move, w_move_nxt;
   logic               r_mirror, w_mirror_nxt;
   logic               r_strobe, w_strobe_nxt;
   logic [7:0]         r_atk_cnt, w_atk_cnt_nxt;
   logic [7:0]         r_stun_cnt, w_stun_cnt_nxt;
   logic               r_hit_pending, w_hit_pending_nxt;
   logic               r_attack_prev, w_attack_prev_nxt;
   logic               w_hit;
   logic               w_press;
   logic               w_mirror_upd;
   logic signed [7:0]  w_y_calc;

   // Saturate a candidate x position into the playfield.
   function automatic logic [6:0] f_clamp(input int v);
      if (v < X_MIN) return 7'(X_MIN);
      if (v > X_MAX) return 7'(X_MAX);
      return 7'(v);
   endfunction

   assign x               = r_x;
   assign y               = r_y;
   assign in_air          = r_in_air;
   assign move_state      = r_move;
   assign character_state = r_state;
   assign mirror          = r_mirror;
   assign hit_strobe      = r_strobe;

   // Next-state and datapath decisions for one frame tick.
   always_comb begin
      w_state_nxt       = r_state;
      w_x_nxt           = r_x;
      w_y_nxt           = r_y;
      w_vy_nxt          = r_vy;
      w_in_air_nxt      = r_in_air;
      w_move_nxt        = r_move;
      w_mirror_nxt      = r_mirror;
      w_strobe_nxt      = 1'b0;
      w_atk_cnt_nxt     = r_atk_cnt;
      w_stun_cnt_nxt    = r_stun_cnt;
      w_hit_pending_nxt = r_hit_pending | hit_in;
      w_attack_prev_nxt = r_attack_prev;
      w_hit             = r_hit_pending | hit_in;
      w_press           = btn_attack & ~r_attack_prev;
      w_mirror_upd      = (opp_x < r_x);
      w_y_calc          = '0;

      if (tick) begin
         // a hit arriving on this very tick is consumed here, not deferred
         w_hit_pending_nxt = 1'b0;
         w_attack_prev_nxt = btn_attack;

         // ballistic motion runs in every state while airborne
         if (r_in_air) begin
            w_y_calc = $signed({1'b0, r_y}) - $signed({{3{r_vy[4]}}, r_vy});
            w_vy_nxt = r_vy - c_GRAV_S;
            if (w_y_calc >= c_Y_GND_S) begin
               w_y_nxt      = 7'(Y_GROUND);
               w_vy_nxt     = '0;
               w_in_air_nxt = 1'b0;
            end else if (w_y_calc < 0) begin
               w_y_nxt = '0;
            end else begin
               w_y_nxt = w_y_calc[6:0];
            end
         end

         if (w_hit && (r_state != ST_HURT)) begin
            // knockback away from the opponent; mirror stays frozen
            w_state_nxt    = ST_HURT;
            w_stun_cnt_nxt = c_STUN_LOAD;
            w_move_nxt     = c_MV_STILL;
            if (opp_x >= r_x) w_x_nxt = f_clamp(int'(r_x) - KNOCKBACK);
            else              w_x_nxt = f_clamp(int'(r_x) + KNOCKBACK);
         end else begin
            case (r_state)
               ST_ATTACK: begin
                  w_move_nxt = c_MV_STILL;
                  if (r_atk_cnt == c_ATK_HALF) w_strobe_nxt = 1'b1;
                  if (r_atk_cnt == 8'd0) w_state_nxt   = ST_NORMAL;
                  else                   w_atk_cnt_nxt = r_atk_cnt - 8'd1;
               end
               ST_HURT: begin
                  w_move_nxt = c_MV_STILL;
                  if (r_stun_cnt == 8'd0) w_state_nxt    = ST_NORMAL;
                  else                    w_stun_cnt_nxt = r_stun_cnt - 8'd1;
               end
               default: begin
                  w_mirror_nxt = w_mirror_upd;
                  // an attack press takes the whole tick: no walk, no jump
                  if (w_press && !r_in_air) begin
                     w_state_nxt   = ST_ATTACK;
                     w_atk_cnt_nxt = c_ATK_LOAD;
                     w_move_nxt    = c_MV_STILL;
                  end else begin
                     if (btn_left && !btn_right) begin
                        w_x_nxt    = f_clamp(int'(r_x) - STEP);
                        w_move_nxt = w_mirror_upd ? c_MV_FWD : c_MV_BACK;
                     end else if (btn_right && !btn_left) begin
                        w_x_nxt    = f_clamp(int'(r_x) + STEP);
                        w_move_nxt = w_mirror_upd ? c_MV_BACK : c_MV_FWD;
                     end else begin
                        w_move_nxt = c_MV_STILL;
                     end
                     // take-off tick leaves y alone; motion starts next tick
                     if (btn_up && !r_in_air) begin
                        w_in_air_nxt = 1'b1;
                        w_vy_nxt     = 5'(JUMP_V);
                     end
                  end
               end
            endcase
         end
      end
   end

   // Character state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_NORMAL;
      else        r_state <= w_state_nxt;
   end

   // Position, physics, timers and edge/hit capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x           <= 7'(X_INIT);
         r_y           <= 7'(Y_GROUND);
         r_vy          <= '0;
         r_in_air      <= 1'b0;
         r_move        <= c_MV_STILL;
         r_mirror      <= 1'b0;
         r_strobe      <= 1'b0;
         r_atk_cnt     <= '0;
         r_stun_cnt    <= '0;
         r_hit_pending <= 1'b0;
         r_attack_prev <= 1'b0;
      end else begin
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_vy          <= w_vy_nxt;
         r_in_air      <= w_in_air_nxt;
         r_move        <= w_move_nxt;
         r_mirror      <= w_mirror_nxt;
         r_strobe      <= w_strobe_nxt;
         r_atk_cnt     <= w_atk_cnt_nxt;
         r_stun_cnt    <= w_stun_cnt_nxt;
         r_hit_pending <= w_hit_pending_nxt;
         r_attack_prev <= w_attack_prev_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fighter_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fighter_controller
//  Description : Self-checking bench for fighter_controller. A behavioural
//                model tracks the character; every cycle the DUT outputs are
//                compared against it. Directed scenarios pin the model with
//                hand-computed values, then randomized traffic follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fighter_controller;

   localparam int X_INIT        = 24;
   localparam int Y_GROUND      = 32;
   localparam int X_MIN         = 8;
   localparam int X_MAX         = 88;
   localparam int STEP          = 1;
   localparam int JUMP_V        = 6;
   localparam int GRAVITY       = 1;
   localparam int ATTACK_TICKS  = 12;
   localparam int HITSTUN_TICKS = 12;
   localparam int KNOCKBACK     = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_attack = 1'b0;
   logic [6:0] opp_x = 7'd80;
   logic       hit_in = 1'b0;
   logic [6:0] x, y;
   logic       in_air, mirror, hit_strobe;
   logic [1:0] move_state;
   logic [2:0] character_state;

   int n_total = 0;
   int n_bad   = 0;
   logic last_strobe = 1'b0;

   fighter_controller #(
      .X_INIT(X_INIT), .Y_GROUND(Y_GROUND), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .STEP(STEP), .JUMP_V(JUMP_V), .GRAVITY(GRAVITY),
      .ATTACK_TICKS(ATTACK_TICKS), .HITSTUN_TICKS(HITSTUN_TICKS),
      .KNOCKBACK(KNOCKBACK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
      .btn_attack(btn_attack), .opp_x(opp_x), .hit_in(hit_in),
      .x(x), .y(y), .in_air(in_air), .move_state(move_state),
      .character_state(character_state), .mirror(mirror),
      .hit_strobe(hit_strobe)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 normal, 1 attack, 2 hurt; age = ticks spent in the mode since entry
   typedef struct packed {
      int x; int y; int vy; int air; int move; int mode;
      int mir; int strobe; int age; int pend; int prev;
   } mstate_t;

   mstate_t m;

   function automatic int f_clamp(input int v);
      if (v < X_MIN) return X_MIN;
      if (v > X_MAX) return X_MAX;
      return v;
   endfunction

   function automatic mstate_t f_reset();
      mstate_t r;
      r = '0;
      r.x = X_INIT;
      r.y = Y_GROUND;
      return r;
   endfunction

   function automatic mstate_t f_step(input mstate_t s);
      mstate_t n;
      int yn, dir, ox;
      bit hit, press, mir;
      n = s;
      n.strobe = 0;
      if (!tick) begin
         n.pend = s.pend | int'(hit_in);
         return n;
      end
      ox    = int'(opp_x);
      hit   = (s.pend != 0) || hit_in;
      press = btn_attack && (s.prev == 0);
      n.pend = 0;
      n.prev = int'(btn_attack);
      if (s.air != 0) begin
         yn   = s.y - s.vy;
         n.vy = s.vy - GRAVITY;
         if (yn >= Y_GROUND) begin
            n.y = Y_GROUND; n.vy = 0; n.air = 0;
         end else if (yn < 0) n.y = 0;
         else n.y = yn;
      end
      if (hit && s.mode != 2) begin
         n.mode = 2; n.age = 0; n.move = 0;
         n.x = f_clamp((ox >= s.x) ? s.x - KNOCKBACK : s.x + KNOCKBACK);
      end else if (s.mode == 1) begin
         n.move = 0;
         if (ATTACK_TICKS - 1 - s.age == ATTACK_TICKS / 2) n.strobe = 1;
         if (s.age == ATTACK_TICKS - 1) n.mode = 0;
         else n.age = s.age + 1;
      end else if (s.mode == 2) begin
         n.move = 0;
         if (s.age == HITSTUN_TICKS - 1) n.mode = 0;
         else n.age = s.age + 1;
      end else begin
         mir   = (ox < s.x);
         n.mir = int'(mir);
         if (press && s.air == 0) begin
            n.mode = 1; n.age = 0; n.move = 0;
         end else begin
            dir = int'(btn_right) - int'(btn_left);
            if (dir != 0) begin
               n.x    = f_clamp(s.x + dir * STEP);
               n.move = ((dir < 0) == mir) ? 1 : 2;
            end else n.move = 0;
            if (btn_up && s.air == 0) begin
               n.air = 1; n.vy = JUMP_V;
            end
         end
      end
      return n;
   endfunction

   // model advances on the same edges as the DUT
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= f_reset();
      else        m <= f_step(m);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("x", int'(x), m.x);
         chk("y", int'(y), m.y);
         chk("in_air", int'(in_air), m.air);
         chk("move_state", int'(move_state), m.move);
         chk("character_state", int'(character_state), m.mode);
         chk("mirror", int'(mirror), m.mir);
         chk("hit_strobe", int'(hit_strobe), m.strobe);
      end
   end

   // called just after a negedge; one tick cycle followed by one idle cycle
   task automatic step_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      last_strobe = hit_strobe;
      @(negedge clk);
   endtask

   task automatic pulse_hit();
      hit_in = 1'b1;
      @(negedge clk);
      hit_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"}, int'(x), X_INIT);
      chk({tag, "_y"}, int'(y), Y_GROUND);
      chk({tag, "_in_air"}, int'(in_air), 0);
      chk({tag, "_move"}, int'(move_state), 0);
      chk({tag, "_state"}, int'(character_state), 0);
      chk({tag, "_mirror"}, int'(mirror), 0);
      chk({tag, "_strobe"}, int'(hit_strobe), 0);
   endtask

   int jump_tab[14] = '{32, 26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26, 32};

   initial begin
      int air_cnt, strobe_at, atk_ticks;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // walk right toward the opponent, then into the right wall
      opp_x = 7'd80; btn_right = 1'b1;
      repeat (10) step_tick();
      chk("walk10_x", int'(x), 34);
      chk("walk10_move", int'(move_state), 1);
      chk("walk10_mirror", int'(mirror), 0);
      repeat (60) step_tick();
      chk("wall_x", int'(x), 88);
      chk("wall_mirror", int'(mirror), 1);
      chk("wall_move", int'(move_state), 2);

      // single jump trajectory
      btn_right = 1'b0; btn_up = 1'b1;
      air_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step_tick();
         btn_up = 1'b0;
         chk($sformatf("jump_y%0d", i), int'(y), jump_tab[i]);
         if (in_air) air_cnt++;
      end
      chk("jump_landed", int'(in_air), 0);
      chk("jump_airticks", air_cnt, 13);

      // walk left to x=50 with the opponent at 60
      opp_x = 7'd60; btn_left = 1'b1;
      repeat (38) step_tick();
      btn_left = 1'b0;
      chk("walkleft_x", int'(x), 50);

      // held attack: 12 ticks of ATTACK, one strobe on tick 7, no retrigger
      btn_attack = 1'b1;
      atk_ticks = 0; strobe_at = -1;
      for (int i = 1; i <= 16; i++) begin
         step_tick();
         if (character_state == 3'b001) atk_ticks++;
         if (last_strobe) strobe_at = (strobe_at == -1) ? i : 99;
      end
      chk("atk_len", atk_ticks, 12);
      chk("atk_strobe_tick", strobe_at, 7);
      chk("atk_no_retrigger", int'(character_state), 0);

      // hit during attack tick 3 on a non-tick cycle
      btn_attack = 1'b0;
      step_tick();
      btn_attack = 1'b1;
      repeat (3) step_tick();
      btn_attack = 1'b0;
      pulse_hit();
      step_tick();
      chk("hit_state", int'(character_state), 2);
      chk("hit_x", int'(x), 46);
      chk("hit_no_strobe", int'(last_strobe), 0);
      repeat (5) step_tick();
      pulse_hit();
      repeat (6) step_tick();
      chk("stun_11", int'(character_state), 2);
      step_tick();
      chk("stun_12", int'(character_state), 0);

      // randomized traffic: irregular ticks, hits on any cycle, button churn
      for (int i = 0; i < 6000; i++) begin
         tick   = ($urandom_range(0, 2) == 0);
         hit_in = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 5) == 0)
            {btn_left, btn_right, btn_up, btn_attack} = 4'($urandom);
         if ($urandom_range(0, 63) == 0) opp_x = 7'($urandom);
         @(negedge clk);
      end
      tick = 1'b0; hit_in = 1'b0;
      {btn_left, btn_right, btn_up, btn_attack} = 4'b0000;
      @(negedge clk);

      // settle, jump, and reset asynchronously mid-flight
      repeat (30) step_tick();
      btn_up = 1'b1;
      step_tick();
      btn_up = 1'b0;
      repeat (3) step_tick();
      chk("midjump_y", int'(y), 17);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step_tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
